// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : int_ctrl_pkg
//  Purpose : Shared types, default constants and helpers for the interrupt
//            controller (FSM state encoding, vector defaults, priority encoder).
//  Ports   : none (package)
//  Revision: 1.0  initial release
// ============================================================================
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [31:0] c_VECTOR_BASE_DEF   = 32'h0000_0020;
  localparam logic [31:0] c_VECTOR_STRIDE_DEF = 32'h0000_0008;

  // Index of the lowest set bit; index 0 has the highest priority.
  // Scanning downward lets the last (lowest) hit overwrite earlier ones.
  function automatic logic [4:0] prio_enc(input logic [31:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/int_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module  : int_ctrl_if
//  Purpose : Bundles the interrupt lines, mask access and CPU handshake of the
//            interrupt controller.
//  Ports   : master = system/CPU side (drives irq_in, mask_we, mask_wdata,
//            int_ack, eret); slave = controller side (drives mask_q,
//            pending_q, int_req, int_cause, int_vector, in_service).
//  Revision: 1.0  initial release
// ============================================================================
interface int_ctrl_if #(
  parameter int N_SRC   = 4,
  parameter int CAUSE_W = 2
);
  logic [N_SRC-1:0]   irq_in;
  logic               mask_we;
  logic [N_SRC-1:0]   mask_wdata;
  logic [N_SRC-1:0]   mask_q;
  logic [N_SRC-1:0]   pending_q;
  logic               int_req;
  logic               int_ack;
  logic [CAUSE_W-1:0] int_cause;
  logic [31:0]        int_vector;
  logic               in_service;
  logic               eret;

  modport master (
    output irq_in, mask_we, mask_wdata, int_ack, eret,
    input  mask_q, pending_q, int_req, int_cause, int_vector, in_service
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, int_ack, eret,
    output mask_q, pending_q, int_req, int_cause, int_vector, in_service
  );
endinterface
`default_nettype wire

// File: rtl/int_edge_latch.sv
`default_nettype none
// ============================================================================
//  Module  : int_edge_latch
//  Purpose : Per-source rising-edge detector and pending latch. A new edge
//            sets its pending bit; a clear request removes it unless an edge
//            arrives in the same cycle (set wins).
//  Ports   : clk, reset     - clock, synchronous active-high reset
//            i_irq[N]       - interrupt lines (synchronous, level)
//            i_clr[N]       - one-hot clear of the acknowledged source
//            o_pending[N]   - latched pending edges
//  Revision: 1.0  initial release
// ============================================================================
module int_edge_latch #(
  parameter int N_SRC = 4
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic [N_SRC-1:0] i_irq,
  input  wire logic [N_SRC-1:0] i_clr,
  output logic      [N_SRC-1:0] o_pending
);

  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] w_rise;

  assign w_rise = i_irq & ~r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev    <= '0;
      r_pending <= '0;
    end else begin
      r_prev    <= i_irq;
      // OR-ing the rise after the clear makes a same-cycle edge survive.
      r_pending <= (r_pending & ~i_clr) | w_rise;
    end
  end

  assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : int_ctrl
//  Purpose : Interrupt controller for the multi-cycle CPU. Latches rising
//            edges, applies mask and fixed priority (bit 0 highest), runs a
//            req/ack handshake with the CPU and blocks further requests until
//            eret (non-nested).
//  Ports   : clk    - system clock, rising edge
//            reset  - synchronous active-high reset
//            bus    - int_ctrl_if.slave: irq_in, mask_we, mask_wdata,
//                     int_ack, eret in; mask_q, pending_q, int_req,
//                     int_cause, int_vector, in_service out
//  Note    : CAUSE_W must equal clog2(N_SRC) (minimum 1); N_SRC <= 32.
//  Revision: 1.0  initial release
// ============================================================================
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int               N_SRC         = 4,
  parameter int               CAUSE_W       = 2,
  parameter logic [31:0]      VECTOR_BASE   = c_VECTOR_BASE_DEF,
  parameter logic [31:0]      VECTOR_STRIDE = c_VECTOR_STRIDE_DEF,
  parameter logic [N_SRC-1:0] MASK_RESET    = {N_SRC{1'b1}}
) (
  input wire logic   clk,
  input wire logic   reset,
  int_ctrl_if.slave  bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_SRC-1:0]   r_mask;
  logic               r_req;
  logic               w_req_nxt;
  logic [CAUSE_W-1:0] r_cause;
  logic [CAUSE_W-1:0] w_cause_nxt;
  logic [31:0]        r_vector;
  logic [31:0]        w_vector_nxt;
  logic               r_in_service;
  logic               w_in_service_nxt;

  logic [N_SRC-1:0]   w_pending;
  logic [N_SRC-1:0]   w_eligible;
  logic               w_any;
  logic [4:0]         w_winner;
  logic [N_SRC-1:0]   w_clr;

  int_edge_latch #(
    .N_SRC (N_SRC)
  ) u_edge_latch (
    .clk       (clk),
    .reset     (reset),
    .i_irq     (bus.irq_in),
    .i_clr     (w_clr),
    .o_pending (w_pending)
  );

  assign w_eligible = w_pending & r_mask;
  assign w_any      = |w_eligible;
  // Winner is taken from the live eligible set, so an edge of higher
  // priority that lands while REQ is waiting preempts the original source.
  assign w_winner   = prio_enc(32'(w_eligible));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= MASK_RESET;
    end else if (bus.mask_we) begin
      r_mask <= bus.mask_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_req        <= 1'b0;
      r_cause      <= '0;
      r_vector     <= VECTOR_BASE;
      r_in_service <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req        <= w_req_nxt;
      r_cause      <= w_cause_nxt;
      r_vector     <= w_vector_nxt;
      r_in_service <= w_in_service_nxt;
    end
  end

  // int_req is registered from the next-state decision so it is asserted
  // exactly while the FSM sits in REQ.
  always_comb begin
    w_state_nxt      = r_state;
    w_req_nxt        = 1'b0;
    w_cause_nxt      = r_cause;
    w_vector_nxt     = r_vector;
    w_in_service_nxt = r_in_service;
    w_clr            = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = REQ;
          w_req_nxt   = 1'b1;
        end
      end
      REQ: begin
        if (bus.int_ack && w_any) begin
          w_state_nxt      = SERVICE;
          w_cause_nxt      = CAUSE_W'(w_winner);
          w_vector_nxt     = VECTOR_BASE + VECTOR_STRIDE * {27'd0, w_winner};
          w_in_service_nxt = 1'b1;
          w_clr            = N_SRC'(1) << w_winner;
        end else if (!w_any) begin
          // Request withdrawn by a mask write before the CPU took it.
          w_state_nxt = IDLE;
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      SERVICE: begin
        // Non-nested: new edges only pend until the handler returns.
        if (bus.eret) begin
          w_state_nxt      = IDLE;
          w_in_service_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.mask_q     = r_mask;
  assign bus.pending_q  = w_pending;
  assign bus.int_req    = r_req;
  assign bus.int_cause  = r_cause;
  assign bus.int_vector = r_vector;
  assign bus.in_service = r_in_service;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_int_ctrl
//  Purpose : Self-checking bench for int_ctrl: directed scenarios followed by
//            random traffic, all compared against a behavioural model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_int_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  int_ctrl_if #(.N_SRC(4), .CAUSE_W(2)) bus ();

  int_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: "requesting" and "serving" flags plus pending/mask sets.
  logic [3:0]  m_prev, m_pend, m_mask;
  bit          m_req, m_serv;
  int          m_cause;
  logic [31:0] m_vec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] irq, input logic ack, input logic er,
                            input logic mwe, input logic [3:0] mwd, input logic rst);
    logic [3:0] elig, np;
    int w;
    if (rst) begin
      m_prev = 0; m_pend = 0; m_mask = 4'hF; m_req = 0; m_serv = 0;
      m_cause = 0; m_vec = 32'h20;
      return;
    end
    elig = m_pend & m_mask;
    np   = m_pend;
    if (m_req) begin
      if (ack && elig != 0) begin
        w = 0;
        while (!elig[w]) w++;
        m_cause = w;
        m_vec   = 32'h20 + 32'(w) * 32'h8;
        np[w]   = 1'b0;
        m_serv  = 1;
        m_req   = 0;
      end else if (elig == 0) begin
        m_req = 0;
      end
    end else if (m_serv) begin
      if (er) m_serv = 0;
    end else if (elig != 0) begin
      m_req = 1;
    end
    m_pend = np | (irq & ~m_prev);
    if (mwe) m_mask = mwd;
    m_prev = irq;
  endtask

  // One clock: drive inputs, advance model at the edge, compare #1 later.
  task automatic cyc(input logic [3:0] irq, input logic ack = 0, input logic er = 0,
                     input logic mwe = 0, input logic [3:0] mwd = 4'h0, input logic rst = 0);
    bus.irq_in = irq; bus.int_ack = ack; bus.eret = er;
    bus.mask_we = mwe; bus.mask_wdata = mwd; reset = rst;
    @(posedge clk);
    model_step(irq, ack, er, mwe, mwd, rst);
    #1;
    chk("mask_q",     32'(bus.mask_q),     32'(m_mask));
    chk("pending_q",  32'(bus.pending_q),  32'(m_pend));
    chk("int_req",    32'(bus.int_req),    32'(m_req));
    chk("int_cause",  32'(bus.int_cause),  32'(m_cause));
    chk("int_vector", bus.int_vector,      m_vec);
    chk("in_service", 32'(bus.in_service), 32'(m_serv));
  endtask

  initial begin
    logic [3:0] irq;
    checks = 0; failures = 0;
    bus.irq_in = 0; bus.int_ack = 0; bus.eret = 0;
    bus.mask_we = 0; bus.mask_wdata = 0; reset = 1;

    // 1: single edge on line 0, held high
    cyc(4'h0, 0, 0, 0, 0, 1);
    cyc(4'h0, 0, 0, 0, 0, 1);
    chk("rst_mask", 32'(bus.mask_q), 32'hF);
    chk("rst_vec", bus.int_vector, 32'h20);
    chk("rst_req", 32'(bus.int_req), 32'h0);
    for (int i = 0; i < 7; i++) cyc(4'h0);
    cyc(4'h1);
    chk("t1_pend", 32'(bus.pending_q), 32'h1);
    chk("t1_req_early", 32'(bus.int_req), 32'h0);
    cyc(4'h1);
    chk("t1_req", 32'(bus.int_req), 32'h1);
    cyc(4'h1);
    cyc(4'h1, 1);
    chk("t1_cause", 32'(bus.int_cause), 32'h0);
    chk("t1_vec", bus.int_vector, 32'h20);
    chk("t1_insvc", 32'(bus.in_service), 32'h1);
    chk("t1_pend0", 32'(bus.pending_q), 32'h0);
    cyc(4'h1); cyc(4'h1, 0, 1); cyc(4'h1); cyc(4'h1);
    chk("t1_noreq", 32'(bus.int_req), 32'h0);

    // 2: lines 1 and 2 together, priority then back-to-back
    cyc(4'h0); cyc(4'h6); cyc(4'h6);
    cyc(4'h6, 1);
    chk("t2_cause", 32'(bus.int_cause), 32'h1);
    chk("t2_vec", bus.int_vector, 32'h28);
    chk("t2_pend", 32'(bus.pending_q), 32'h4);
    cyc(4'h6, 0, 1);
    chk("t2_idle", 32'(bus.int_req), 32'h0);
    cyc(4'h6);
    chk("t2_req", 32'(bus.int_req), 32'h1);
    cyc(4'h6, 1);
    chk("t2_vec2", bus.int_vector, 32'h30);
    cyc(4'h0, 0, 1);

    // 3: masked source still pends, unmask raises request
    cyc(4'h0, 0, 0, 1, 4'hE);
    cyc(4'h1); cyc(4'h1); cyc(4'h1);
    chk("t3_pend", 32'(bus.pending_q), 32'h1);
    chk("t3_noreq", 32'(bus.int_req), 32'h0);
    cyc(4'h1, 0, 0, 1, 4'hF);
    chk("t3_req_w", 32'(bus.int_req), 32'h0);
    cyc(4'h1);
    chk("t3_req", 32'(bus.int_req), 32'h1);
    cyc(4'h1, 1); cyc(4'h1, 0, 1);

    // 4: edge during service only pends
    cyc(4'h3); cyc(4'h3); cyc(4'h3, 1);
    cyc(4'hB); cyc(4'hB);
    chk("t4_noreq", 32'(bus.int_req), 32'h0);
    chk("t4_pend3", 32'(bus.pending_q[3]), 32'h1);
    cyc(4'hB, 0, 1); cyc(4'hB);
    cyc(4'hB, 1);
    chk("t4_cause", 32'(bus.int_cause), 32'h3);
    cyc(4'hB, 0, 1);

    // 5: higher-priority edge preempts before ack
    cyc(4'h0); cyc(4'h4); cyc(4'h4);
    cyc(4'h5);
    cyc(4'h5, 1);
    chk("t5_cause", 32'(bus.int_cause), 32'h0);
    chk("t5_pend2", 32'(bus.pending_q), 32'h4);
    cyc(4'h5, 0, 1); cyc(4'h5); cyc(4'h5, 1); cyc(4'h5, 0, 1);

    // 6: reset in service with pending 1010, then stray ack/eret in IDLE
    cyc(4'h0); cyc(4'h1); cyc(4'h1); cyc(4'h1, 1);
    cyc(4'hB);
    chk("t6_pend", 32'(bus.pending_q), 32'hA);
    cyc(4'h0, 0, 0, 0, 0, 1);
    chk("t6_insvc", 32'(bus.in_service), 32'h0);
    chk("t6_pend0", 32'(bus.pending_q), 32'h0);
    cyc(4'h0, 1); cyc(4'h0, 0, 1);
    chk("t6_req", 32'(bus.int_req), 32'h0);

    // Random traffic against the model
    irq = 4'h0;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
      cyc(irq, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 149) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
